// File: rtl/hub75_bcm_driver_if.sv
// hub75_bcm_driver_if
//   Scanner-side bus of the HUB75 BCM driver: row/plane start request,
//   pixel fetch handshake and latch-done pulse.
//   master : frame-buffer scanner (drives in_*, observes out_*)
//   slave  : hub75_bcm_driver     (observes in_*, drives out_*)
//   in_INIT   start one row/plane shift (taken only while out_READY=1)
//   in_ROW    row index, captured with in_INIT
//   in_PLANE  bit-plane index, captured with in_INIT
//   in_DIM    halve the display time, sampled at latch
//   in_RGB    pixel bits for out_COL, valid the cycle after out_REQ
//   out_READY idle and able to accept in_INIT
//   out_REQ   pixel fetch strobe
//   out_COL   column being fetched
//   out_DONE  one-cycle pulse when a row/plane is latched
interface hub75_bcm_driver_if #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5,
    parameter int LANES    = 2,
    parameter int PLANES   = 4
);
    localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int CW = $clog2(COLS);

    logic                 in_INIT;
    logic [ROW_BITS-1:0]  in_ROW;
    logic [PW-1:0]        in_PLANE;
    logic                 in_DIM;
    logic [3*LANES-1:0]   in_RGB;
    logic                 out_READY;
    logic                 out_REQ;
    logic [CW-1:0]        out_COL;
    logic                 out_DONE;

    modport master (
        output in_INIT, in_ROW, in_PLANE, in_DIM, in_RGB,
        input  out_READY, out_REQ, out_COL, out_DONE
    );
    modport slave (
        input  in_INIT, in_ROW, in_PLANE, in_DIM, in_RGB,
        output out_READY, out_REQ, out_COL, out_DONE
    );
endinterface

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver
//   HUB75 panel driver with binary-code-modulation brightness. Shifts one
//   row of one bit-plane per request while the previously latched plane is
//   still being displayed; the display window is timed by on_cnt, which runs
//   independently of the shift state machine.
// Ports:
//   clk             system clock, all logic on posedge
//   rst             asynchronous active-high reset
//   bus             scanner bus (hub75_bcm_driver_if.slave)
//   w_RGB           panel data (3 bits per lane)
//   w_SCREEN_CLOCK  panel shift clock
//   w_ABCDE         panel row address
//   w_LATCH         panel latch
//   w_nOE           panel output enable, active low
// Configuration:
//   HUB75_DEADTIME_EN  when defined, WAIT_DISP holds DEADTIME extra blanked
//                      cycles after the display window before latching.
module hub75_bcm_driver #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5,
    parameter int LANES    = 2,
    parameter int PLANES   = 4,
    parameter int BASE_ON  = 8,
    parameter int DEADTIME = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    hub75_bcm_driver_if.slave    bus,
    output logic [3*LANES-1:0]   w_RGB,
    output logic                 w_SCREEN_CLOCK,
    output logic [ROW_BITS-1:0]  w_ABCDE,
    output logic                 w_LATCH,
    output logic                 w_nOE
);
    localparam int PW  = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int CW  = $clog2(COLS);
    localparam int ONW = $clog2(BASE_ON << (PLANES - 1)) + 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, CLK_HI, WAIT_DISP, LATCH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        col_q;
    logic [ROW_BITS-1:0]  row_q;
    logic [PW-1:0]        plane_q, plane_c;
    logic [ONW-1:0]       on_cnt_q, on_val;
    logic [3*LANES-1:0]   rgb_q;
    logic [ROW_BITS-1:0]  abcde_q;
    logic                 ready_q;
    logic                 accept, last_col, disp_done;

    // ready_q is only ever high in IDLE, so it alone qualifies a start.
    assign accept   = ready_q & bus.in_INIT;
    assign last_col = (col_q == CW'(COLS - 1));

`ifdef HUB75_DEADTIME_EN
    localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
    logic [DW-1:0] dead_q;

    // Counts blanked cycles spent in WAIT_DISP after the window has closed.
    assign disp_done = (on_cnt_q == '0) && (dead_q == DW'(DEADTIME));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dead_q <= '0;
        else if (state_q != WAIT_DISP || on_cnt_q != '0)
            dead_q <= '0;
        else if (dead_q != DW'(DEADTIME))
            dead_q <= dead_q + 1'b1;
    end
`else
    logic unused_deadtime;
    assign unused_deadtime = (DEADTIME != 0);
    assign disp_done       = (on_cnt_q == '0);
`endif

    // Out-of-range planes clamp to the heaviest weight.
    always_comb begin
        plane_c = bus.in_PLANE;
        if (int'(bus.in_PLANE) >= PLANES) plane_c = PW'(PLANES - 1);
    end

    // Display time for the captured plane; DIM is taken live at latch.
    always_comb begin
        on_val = ONW'(BASE_ON) << plane_q;
        if (bus.in_DIM) on_val = on_val >> 1;
        if (on_val == '0) on_val = ONW'(1);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = FETCH;
            FETCH:     state_d = LOAD;
            LOAD:      state_d = CLK_HI;
            CLK_HI:    state_d = last_col ? WAIT_DISP : FETCH;
            WAIT_DISP: if (disp_done) state_d = LATCH;
            LATCH:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.out_REQ    = 1'b0;
        bus.out_DONE   = 1'b0;
        w_SCREEN_CLOCK = 1'b0;
        w_LATCH        = 1'b0;
        case (state_q)
            FETCH:  bus.out_REQ = 1'b1;
            CLK_HI: w_SCREEN_CLOCK = 1'b1;
            LATCH: begin
                w_LATCH      = 1'b1;
                bus.out_DONE = 1'b1;
            end
            default: ;
        endcase
        // Blank during latch so the row address and data never change while lit.
        w_nOE = (on_cnt_q == '0) || (state_q == LATCH);
    end

    assign bus.out_READY = ready_q;
    assign bus.out_COL   = col_q;
    assign w_RGB         = rgb_q;
    assign w_ABCDE       = abcde_q;

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b0;
            on_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            plane_q  <= '0;
            rgb_q    <= '0;
            abcde_q  <= '0;
        end else begin
            ready_q <= (state_d == IDLE);
            // Display window runs in every state so the next shift overlaps it.
            if (on_cnt_q != '0) on_cnt_q <= on_cnt_q - 1'b1;
            case (state_q)
                IDLE: if (accept) begin
                    row_q   <= bus.in_ROW;
                    plane_q <= plane_c;
                    col_q   <= '0;
                end
                LOAD:   rgb_q <= bus.in_RGB;
                CLK_HI: if (!last_col) col_q <= col_q + 1'b1;
                LATCH: begin
                    abcde_q  <= row_q;
                    on_cnt_q <= on_val;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hub75_bcm_driver.sv
module tb_hub75_bcm_driver;
    localparam int COLS = 4, ROW_BITS = 5, LANES = 2, PLANES = 4, BASE_ON = 8, DEADTIME = 2;
`ifdef HUB75_DEADTIME_EN
    localparam int DT = DEADTIME;
`else
    localparam int DT = 0;
`endif
    localparam int RGBW = 3 * LANES;
    localparam int PW = $clog2(PLANES);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [RGBW-1:0]     w_RGB;
    logic                w_SCREEN_CLOCK, w_LATCH, w_nOE;
    logic [ROW_BITS-1:0] w_ABCDE;

    hub75_bcm_driver_if #(.COLS(COLS), .ROW_BITS(ROW_BITS), .LANES(LANES), .PLANES(PLANES)) bus ();

    hub75_bcm_driver #(.COLS(COLS), .ROW_BITS(ROW_BITS), .LANES(LANES), .PLANES(PLANES),
                       .BASE_ON(BASE_ON), .DEADTIME(DEADTIME)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .w_RGB(w_RGB), .w_SCREEN_CLOCK(w_SCREEN_CLOCK), .w_ABCDE(w_ABCDE),
        .w_LATCH(w_LATCH), .w_nOE(w_nOE)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0;

    // Reference model: one transaction in flight plus the last latched window.
    bit  busy = 0;
    int  t0 = 0, lat_at = 0, row_m = 0, on_m = 0;
    int  lp = -1000, onp = 0;
    int  ready_from = 32'h7fffffff;
    logic [RGBW-1:0]     exp_rgb = '0, rgb_drv = '0;
    logic [ROW_BITS-1:0] exp_abcde = '0;
    bit  fixed_rgb = 0;

    // Observations for directed checks
    int  obs_latch = 0, lit_cnt = 0;
    int  sclk_q[$];
    logic prev_sclk = 1'b0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int on_time(int p, bit d);
        int v;
        v = (BASE_ON << p) >> d;
        return (v < 1) ? 1 : v;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic check_cycle();
        int k;
        bit e_req, e_sclk, e_latch, e_noe, e_ready;
        int e_col;
        e_req = 0; e_sclk = 0; e_latch = 0; e_col = 0;
        if (busy) begin
            k = cyc - t0 - 1;
            if (k < 3 * COLS) begin
                e_req  = (k % 3 == 0);
                e_sclk = (k % 3 == 2);
                e_col  = k / 3;
            end
            e_latch = (cyc == lat_at);
        end
        e_noe   = !(cyc >= lp + 1 && cyc <= lp + onp);
        e_ready = !busy && cyc > lp && cyc >= ready_from;
        chk("req",   bus.out_REQ, e_req);
        chk("sclk",  w_SCREEN_CLOCK, e_sclk);
        chk("latch", w_LATCH, e_latch);
        chk("done",  bus.out_DONE, e_latch);
        chk("noe",   w_nOE, e_noe);
        chk("ready", bus.out_READY, e_ready);
        chk("rgb",   w_RGB, exp_rgb);
        chk("abcde", w_ABCDE, exp_abcde);
        if (e_req) chk("col", bus.out_COL, e_col);
        // directed observations
        if (w_SCREEN_CLOCK && !prev_sclk) sclk_q.push_back(cyc);
        prev_sclk = w_SCREEN_CLOCK;
        if (w_LATCH) begin obs_latch = cyc; lit_cnt = 0; end
        else if (!w_nOE) lit_cnt++;
        // retire transaction at its latch
        if (busy && cyc == lat_at) begin
            lp = lat_at; onp = on_m; exp_abcde = row_m[ROW_BITS-1:0]; busy = 0;
        end
    endtask

    task automatic step();
        bit was_load;
        int k;
        was_load = 0;
        if (busy) begin
            k = cyc - t0 - 1;
            if (k >= 0 && k < 3 * COLS && k % 3 == 1) was_load = 1;
        end
        @(posedge clk);
        cyc++;
        if (was_load) exp_rgb = rgb_drv;
        #1;
        check_cycle();
        bus.in_INIT = 1'b0;
        bus.in_RGB  = fixed_rgb ? RGBW'(6'h2A) : RGBW'($urandom());
        rgb_drv     = bus.in_RGB;
    endtask

    task automatic start(int row, int plane, bit dim);
        bus.in_INIT  = 1'b1;
        bus.in_ROW   = row[ROW_BITS-1:0];
        bus.in_PLANE = plane[PW-1:0];
        bus.in_DIM   = dim;
        if (!busy && cyc > lp && cyc >= ready_from) begin
            busy   = 1;
            t0     = cyc;
            row_m  = row;
            on_m   = on_time(plane, dim);
            lat_at = imax(t0 + 3 * COLS + 1, lp + onp + 1) + DT + 1;
        end
    endtask

    // Start pulse while a shift is in progress; in_DIM is left alone.
    task automatic poke(int row, int plane);
        bus.in_INIT  = 1'b1;
        bus.in_ROW   = row[ROW_BITS-1:0];
        bus.in_PLANE = plane[PW-1:0];
    endtask

    task automatic wait_busy();
        int b;
        b = 0;
        while (busy && b < 1000) begin step(); b++; end
        chk("busy_timeout", b < 1000, 1);
    endtask

    task automatic settle();
        int b;
        b = 0;
        while ((busy || cyc <= lp + onp) && b < 1000) begin step(); b++; end
        chk("settle_timeout", b < 1000, 1);
    endtask

    int t_a, lat1, t_i;

    initial begin
        bus.in_INIT = 0; bus.in_ROW = '0; bus.in_PLANE = '0; bus.in_DIM = 0; bus.in_RGB = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.out_READY, 0);
        chk("rst_noe",   w_nOE, 1);
        chk("rst_latch", w_LATCH, 0);
        chk("rst_sclk",  w_SCREEN_CLOCK, 0);
        chk("rst_rgb",   w_RGB, 0);
        chk("rst_abcde", w_ABCDE, 0);
        chk("rst_req",   bus.out_REQ, 0);
        chk("rst_col",   bus.out_COL, 0);
        chk("rst_done",  bus.out_DONE, 0);
        rst = 1'b0;
        ready_from = cyc + 1;
        step();

        // Single row, plane 0, fixed pixels
        fixed_rgb = 1;
        sclk_q.delete();
        start(3, 0, 0); t_a = cyc;
        settle();
        fixed_rgb = 0;
        chk("A_latch_rel", obs_latch - t_a, 14 + DT);
        chk("A_lit", lit_cnt, 8);
        chk("A_sclk_n", sclk_q.size(), 4);
        for (int i = 0; i < sclk_q.size() && i < 4; i++)
            chk("A_sclk_rel", sclk_q[i] - t_a, 3 + 3 * i);
        chk("A_row", w_ABCDE, 3);
        chk("A_rgb", w_RGB, 6'h2A);

        // BCM weights
        start(7, 3, 0); settle();
        chk("B_lit64", lit_cnt, 64);
        start(8, 3, 1); settle();
        chk("C_lit32", lit_cnt, 32);

        // Overlap: second shift runs under the first plane's display
        start(5, 3, 0); wait_busy();
        lat1 = obs_latch;
        step();
        sclk_q.delete();
        start(6, 3, 0); wait_busy();
        chk("ovl_gap", obs_latch - lat1, 66 + DT);
        chk("ovl_shift_lit", sclk_q.size() == 4 && sclk_q[3] <= lat1 + 64, 1);
        step();
        chk("ovl_row", w_ABCDE, 6);
        settle();

        // Ignored start mid-shift
        start(9, 1, 0); t_i = cyc;
        repeat (5) step();
        poke(17, 2);
        settle();
        chk("ign_row", w_ABCDE, 9);
        chk("ign_latch_rel", obs_latch - t_i, 14 + DT);
        chk("ign_lit", lit_cnt, 16);

        // Randomised back-to-back traffic with spurious starts
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) step();
            wait_busy();
            if (cyc <= lp) step();
            start($urandom_range(0, 31), $urandom_range(0, PLANES - 1), 1'($urandom_range(0, 1)));
            for (int b = 0; busy && b < 400; b++) begin
                step();
                if (busy && $urandom_range(0, 9) == 0)
                    poke($urandom_range(0, 31), $urandom_range(0, PLANES - 1));
            end
        end
        settle();

        // Asynchronous reset mid-display at on_cnt == 20
        start(4, 3, 0); wait_busy();
        for (int b = 0; cyc < lp + onp - 19 && b < 200; b++) step();
        chk("rst_point", cyc, lp + onp - 19);
        chk("pre_rst_noe", w_nOE, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst_noe", w_nOE, 1);
        chk("arst_latch", w_LATCH, 0);
        chk("arst_ready", bus.out_READY, 0);
        busy = 0; lp = -1000; onp = 0; exp_rgb = '0; exp_abcde = '0; ready_from = 32'h7fffffff;
        step(); step();
        rst = 1'b0;
        ready_from = cyc + 1;
        #1 chk("rel_ready_low", bus.out_READY, 0);
        step();
        chk("rel_ready_high", bus.out_READY, 1);
        start(2, 0, 0); settle();
        chk("post_rst_row", w_ABCDE, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/hub75_bcm_driver.md
# hub75_bcm_driver

Parameterised HUB75 panel driver for the GPU display path that shifts one row of one bit-plane per request and overlaps that shift with the timed display window of the previously latched plane. It supports multi-lane panels, arbitrary row counts and binary-code-modulation (BCM) brightness. It sits between the frame-buffer scanner, which supplies row/plane indices and pixel data, and the panel pins. It replaces the single-plane driver and its separate column clocker.

## Interface
- COLS, 64: columns shifted per row; at least 2.
- ROW_BITS, 5: width of the row address (ABCDE).
- LANES, 2: simultaneous RGB lanes (upper/lower half, or more for chained panels).
- PLANES, 4: BCM bit depth.
- BASE_ON, 8: display cycles for plane 0; plane p gets BASE_ON<<p.
- DEADTIME, 2: blanking cycles before latch; used only with HUB75_DEADTIME_EN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_INIT  in  1  start one row/plane shift; accepted only while out_READY=1.
- in_ROW  in  ROW_BITS  row index, captured with in_INIT.
- in_PLANE  in  $clog2(PLANES)  bit-plane index, captured with in_INIT.
- in_DIM  in  1  halves the display time; sampled at latch.
- in_RGB  in  3*LANES  pixel bits for out_COL; valid one cycle after out_REQ.
- out_READY  out  1  idle and able to accept in_INIT.
- out_REQ  out  1  pixel fetch strobe.
- out_COL  out  $clog2(COLS)  column being fetched.
- out_DONE  out  1  one-cycle pulse when a row/plane is latched.
- w_RGB  out  3*LANES  panel data.
- w_SCREEN_CLOCK  out  1  panel shift clock.
- w_ABCDE  out  ROW_BITS  panel row address.
- w_LATCH  out  1  panel latch.
- w_nOE  out  1  panel output enable, active low.

## Operation

**Control state machine.** States are IDLE, FETCH, LOAD, CLK_HI, WAIT_DISP and LATCH. Display is handled by an independent down-counter `on_cnt`.

- **IDLE**
  - out_READY=1.
  - in_INIT=1 captures in_ROW and in_PLANE, clears the column counter and goes to FETCH.
  - in_INIT outside IDLE is ignored; it is neither queued nor allowed to corrupt the captured values.
- **FETCH**
  - out_REQ=1, out_COL=c.
  - w_SCREEN_CLOCK=0.
  - Next state: LOAD.
- **LOAD**
  - w_RGB<=in_RGB at the end of the cycle.
  - w_SCREEN_CLOCK=0.
  - Next state: CLK_HI.
- **CLK_HI**
  - w_SCREEN_CLOCK=1; data has been stable for at least one cycle.
  - If c==COLS-1, go to WAIT_DISP; otherwise c++ and go to FETCH.
- **WAIT_DISP**
  - w_SCREEN_CLOCK=0.
  - Hold until on_cnt==0, plus DEADTIME further cycles when the macro is enabled.
  - Then go to LATCH.
- **LATCH**
  - w_LATCH=1 and w_nOE=1.
  - w_ABCDE<=captured row.
  - on_cnt<=ON, where ON = BASE_ON<<plane, shifted right by 1 when in_DIM=1, with a minimum of 1.
  - out_DONE=1.
  - Next state: IDLE.

**Output enable.** w_nOE = (on_cnt==0) | (state==LATCH). on_cnt decrements every cycle while non-zero, in every state. The next row therefore shifts while the current plane is lit.

**Row address.** w_ABCDE changes only in LATCH, when w_nOE=1, so a row address never changes while the panel is lit.

**Width and range rules.**
- on_cnt width is $clog2(BASE_ON<<(PLANES-1))+1.
- in_PLANE >= PLANES is clamped to PLANES-1.
- The column counter wraps only through the COLS-1 compare and never overflows.

**Reset.** Reset is asynchronous, including mid-shift or mid-display. Reset values:
- state=IDLE, on_cnt=0.
- w_RGB=0, w_SCREEN_CLOCK=0, w_ABCDE=0, w_LATCH=0, w_nOE=1.
- out_REQ=0, out_COL=0, out_DONE=0, out_READY=0.
- out_READY is registered and rises on the first posedge after rst deasserts.

## Timing
- Cycle 0: in_INIT is sampled high in IDLE.
- Column c: FETCH at cycle 1+3c, LOAD at 2+3c, CLK_HI at 3+3c.
- Shift length is exactly 3*COLS cycles.
- WAIT_DISP starts at 3*COLS+1 and lasts at least 1 cycle.
- LATCH is at 3*COLS+2 in the minimal case, with on_cnt already 0 and no macro.
- After LATCH:
  - out_READY=1 on the next cycle.
  - w_nOE is low for exactly ON cycles, starting the cycle after LATCH.
- in_INIT in the first cycle out_READY=1 is legal; back-to-back rows need no idle gap.
- w_nOE must never be low in the same cycle as w_LATCH=1 or a w_ABCDE change.

## Configuration
- HUB75_DEADTIME_EN defined:
  - WAIT_DISP adds DEADTIME cycles with w_nOE=1 after on_cnt reaches 0, before LATCH. This suppresses ghosting.
  - Minimal LATCH moves to 3*COLS+2+DEADTIME when on_cnt is already 0.
- Undefined: LATCH follows the first WAIT_DISP cycle that sees on_cnt==0, and DEADTIME is ignored.

## Test plan
- Single row, COLS=4, LANES=2, macro off: reset, then in_INIT with row=3, plane=0, in_RGB=6'h2A on every fetch. Required response:
  - 4 rising edges of w_SCREEN_CLOCK at cycles 3, 6, 9, 12.
  - w_LATCH at cycle 14 with w_ABCDE=3.
  - w_nOE low for cycles 15..22 (8 cycles).
  - out_DONE at cycle 14.
- BCM weight: plane=3, BASE_ON=8 -> w_nOE low for 64 cycles. Repeat with in_DIM=1 -> 32 cycles.
- Overlap: issue in_INIT for plane 3 immediately after out_DONE. Required response: the second shift completes during display, WAIT_DISP holds until on_cnt=0, the second latch occurs on the cycle after nOE returns high, and nOE never goes low during latch.
- Ignored start: in_INIT pulsed at cycle 5 of a shift with a different row -> captured row, column count and timing are unchanged.
- Reset mid-display: assert rst asynchronously while on_cnt=20 -> w_nOE=1 and w_LATCH=0 immediately, before the next clock edge; out_READY rises one edge after release.
- HUB75_DEADTIME_EN, DEADTIME=2, COLS=4: LATCH at cycle 16, and w_nOE stays high through cycles 14..16.
